// File: rtl/cpu_pkg.sv
// Shared CPU definitions: pipeline-control FSM encoding, control-word layout
// and the architectural zero-register index.
package cpu_pkg;

    localparam logic [4:0] XZR_IDX = 5'd31;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_flush;
    } ctrl_t;

    // Pipeline frozen and every stage emptied; used in INIT and under reset.
    localparam ctrl_t CTRL_INIT   = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                      id_ex_bubble: 1'b1, ex_mem_flush: 1'b1};
    localparam ctrl_t CTRL_RUN    = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                      id_ex_bubble: 1'b0, ex_mem_flush: 1'b0};
    localparam ctrl_t CTRL_STALL  = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                      id_ex_bubble: 1'b1, ex_mem_flush: 1'b0};
    localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                      id_ex_bubble: 1'b1, ex_mem_flush: 1'b1};
    // The instruction ROM is registered, so one more fetched word is stale.
    localparam ctrl_t CTRL_FLUSH  = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                      id_ex_bubble: 1'b0, ex_mem_flush: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Load-use / RAW hazard compare between the IF/ID sources and the destinations
// still in flight in ID/EX, EX/MEM and MEM/WB.
module hazard_detect
    import cpu_pkg::*;
#(
    parameter logic [4:0] ZR_IDX = XZR_IDX
) (
    input  logic [4:0] id_rn,
    input  logic [4:0] id_rm,
    input  logic       id_use_rn,
    input  logic       id_use_rm,
    input  logic [4:0] ex_rd,
    input  logic [4:0] mem_rd,
    input  logic [4:0] wb_rd,
    input  logic       ex_regwrite,
    input  logic       mem_regwrite,
    input  logic       wb_regwrite,
    output logic       hazard
);

    logic rn_live;
    logic rm_live;
    logic rn_hit;
    logic rm_hit;

    // XZR reads always return zero, so they can never depend on a writer.
    assign rn_live = id_use_rn && (id_rn != ZR_IDX);
    assign rm_live = id_use_rm && (id_rm != ZR_IDX);

    assign rn_hit = (ex_regwrite  && (ex_rd  == id_rn)) ||
                    (mem_regwrite && (mem_rd == id_rn)) ||
                    (wb_regwrite  && (wb_rd  == id_rn));
    assign rm_hit = (ex_regwrite  && (ex_rd  == id_rm)) ||
                    (mem_regwrite && (mem_rd == id_rm)) ||
                    (wb_regwrite  && (wb_rd  == id_rm));

    assign hazard = (rn_live && rn_hit) || (rm_live && rm_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control FSM: PC / IF-ID enables, stage flushes and bubbles, plus
// saturating stall and flush performance counters.
module pipeline_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W  = 32,
    parameter logic [4:0]  ZR_IDX = XZR_IDX
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             ex_regwrite,
    input  logic             mem_regwrite,
    input  logic             wb_regwrite,
    input  logic             br_taken,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [1:0]       state_o
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    ctrl_t            ctrl;
    logic             hazard;
    logic             stall_evt;
    logic             flush_evt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    hazard_detect #(
        .ZR_IDX(ZR_IDX)
    ) u_hazard (
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .id_use_rn   (id_use_rn),
        .id_use_rm   (id_use_rm),
        .ex_rd       (ex_rd),
        .mem_rd      (mem_rd),
        .wb_rd       (wb_rd),
        .ex_regwrite (ex_regwrite),
        .mem_regwrite(mem_regwrite),
        .wb_regwrite (wb_regwrite),
        .hazard      (hazard)
    );

    // RUN and STALL share one decision: branch beats hazard beats normal flow.
    always_comb begin
        ctrl      = CTRL_INIT;
        state_d   = state_q;
        stall_evt = 1'b0;
        flush_evt = 1'b0;
        if (reset) begin
            ctrl    = CTRL_INIT;
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT: begin
                    ctrl    = CTRL_INIT;
                    state_d = ST_RUN;
                end
                ST_RUN, ST_STALL: begin
                    if (br_taken) begin
                        ctrl      = CTRL_BRANCH;
                        state_d   = ST_FLUSH;
                        flush_evt = 1'b1;
                    end else if (hazard) begin
                        ctrl      = CTRL_STALL;
                        state_d   = ST_STALL;
                        stall_evt = 1'b1;
                    end else begin
                        ctrl    = CTRL_RUN;
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    // A taken branch here would come from a flushed slot; ignore it.
                    ctrl    = CTRL_FLUSH;
                    state_d = ST_RUN;
                end
                default: begin
                    ctrl    = CTRL_INIT;
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_INIT;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_evt) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (flush_evt) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_bubble = ctrl.id_ex_bubble;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
    assign state_o      = state_q;

endmodule
